ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requester channels (2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, store/load data width.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before a transaction is forced to error (1..65535).
REQ-005 SHALL have port CLK, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port memREN, input, NUM_CH, per-channel read request.
REQ-008 SHALL have port memWEN, input, NUM_CH, per-channel write request.
REQ-009 SHALL have port memaddr, input, NUM_CH*ADDR_W, per-channel address, channel i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port memstore, input, NUM_CH*DATA_W, per-channel write data, packed the same way.
REQ-011 SHALL have port chstate, output, NUM_CH*2, per-channel ramstate_t (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-012 SHALL have port chload, output, NUM_CH*DATA_W, per-channel read data.
REQ-013 SHALL have port ramREN, output, 1, read strobe to RAM.
REQ-014 SHALL have port ramWEN, output, 1, write strobe to RAM.
REQ-015 SHALL have port ramaddr, output, ADDR_W, address to RAM.
REQ-016 SHALL have port ramstore, output, DATA_W, write data to RAM.
REQ-017 SHALL have port ramstate, input, 2, RAM status (ramstate_t).
REQ-018 SHALL have port ramload, input, DATA_W, read data from RAM.
REQ-019 SHALL have port grant, output, $clog2(NUM_CH), channel currently owning the RAM.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT, TOUT.
REQ-021 Channel i is "requesting" when memREN[i] | memWEN[i]; IDLE with any requester SHALL select one round-robin starting at (last+1) mod NUM_CH, latch its addr, store data and op, set grant, go WAIT next edge.
REQ-022 When a channel asserts both memREN and memWEN, latched op SHALL be write; no read issued.
REQ-023 In WAIT, ramREN/ramWEN/ramaddr/ramstore SHALL be driven from latched values; in IDLE and TOUT, ramREN=ramWEN=0, ramaddr/ramstore=0.
REQ-024 In WAIT with ramstate==ACCESS, chstate[grant] SHALL be ACCESS combinationally that cycle, chload[grant]=ramload, last<=grant, next state IDLE.
REQ-025 In WAIT with ramstate==ERROR, chstate[grant] SHALL be ERROR that cycle, last<=grant, next state IDLE.
REQ-026 In WAIT, a cycle counter SHALL increment each cycle without ACCESS/ERROR; reaching TIMEOUT SHALL move to TOUT, where chstate[grant]=ERROR for exactly one cycle, then IDLE, last<=grant.
REQ-027 Counter SHALL clear on entry to WAIT; width $clog2(TIMEOUT+1); no wrap.
REQ-028 Non-granted channels SHALL read BUSY while requesting and FREE otherwise; granted channel SHALL read BUSY in WAIT except as in REQ-024/025.
REQ-029 chload for non-granted channels and outside ACCESS SHALL be 0.
REQ-030 Latency: request seen in IDLE at cycle 0 -> ramREN/WEN at cycle 1; RAM returning ACCESS at cycle k -> next grant decided at k+1, issued k+2.
REQ-031 Requester dropping its request during WAIT SHALL NOT abort the transaction; result returned per REQ-024 regardless.
REQ-032 Changes to memaddr/memstore during WAIT SHALL NOT affect ram outputs.
REQ-033 Single persistent requester SHALL be re-granted back-to-back with one IDLE cycle between transactions.

Reset
REQ-034 nRST low SHALL asynchronously force IDLE, last=NUM_CH-1, grant=0, counter=0, ramREN=ramWEN=0, ramaddr=ramstore=0, all chload=0; chstate per REQ-028 (FREE/BUSY from inputs).
REQ-035 Reset asserted during WAIT SHALL drop ramREN/ramWEN immediately; no channel receives ACCESS for the aborted transaction.

Verification
REQ-036 NUM_CH=4; ch0 read addr 0x100, RAM ACCESS after 3 cycles with ramload=0xDEADBEEF -> ramREN at cycle 1, chstate[0]=ACCESS and chload[0]=0xDEADBEEF at cycle 3, grant=0.
REQ-037 ch0..ch3 all request continuously, RAM ACCESS immediate -> grants 0,1,2,3,0 in order, each channel served once per 4 transactions.
REQ-038 ch2 sets memREN=memWEN=1, addr 0x40, store 0x55 -> ramWEN=1, ramREN=0, ramstore=0x55 at cycle 1.
REQ-039 TIMEOUT=8, RAM held BUSY -> TOUT after 8 WAIT cycles, chstate[grant]=ERROR one cycle, ramREN low, then IDLE.
REQ-040 ch1 read in WAIT, nRST pulsed low -> ramREN 0 immediately, chstate[1] never ACCESS, after release ch0 granted first if requesting.
REQ-041 RAM returns ERROR on ch3 write -> chstate[3]=ERROR one cycle, next grant goes to ch0 when ch0 and ch3 both request.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one RAM port among NUM_CH requesters,
// with a per-transaction wait timeout that reports ERROR to the owning channel.
module ram_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NUM_CH-1:0]          memREN,
  input  logic [NUM_CH-1:0]          memWEN,
  input  logic [NUM_CH*ADDR_W-1:0]   memaddr,
  input  logic [NUM_CH*DATA_W-1:0]   memstore,
  output logic [NUM_CH*2-1:0]        chstate,
  output logic [NUM_CH*DATA_W-1:0]   chload,
  output logic                       ramREN,
  output logic                       ramWEN,
  output logic [ADDR_W-1:0]          ramaddr,
  output logic [DATA_W-1:0]          ramstore,
  input  logic [1:0]                 ramstate,
  input  logic [DATA_W-1:0]          ramload,
  output logic [$clog2(NUM_CH)-1:0]  grant
);
  localparam int GW = $clog2(NUM_CH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  typedef enum logic [1:0] {IDLE, WAIT, TOUT} state_t;
  state_t state, state_n;
  logic [GW-1:0] last, pick;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_store;
  logic lat_wr, any_req, done;
  logic [NUM_CH-1:0] req;
  assign req = memREN | memWEN;
  assign done = ramstate inside {ACCESS, ERROR};
  function automatic logic [GW-1:0] rr(input logic [GW-1:0] l, input int k);
    int j;
    j = int'(l) + k;
    return GW'(j >= NUM_CH ? j - NUM_CH : j);
  endfunction
  // walk from lowest to highest priority so the channel right after `last` wins
  always_comb begin
    pick = '0;
    any_req = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (req[rr(last, k)]) begin
        pick = rr(last, k);
        any_req = 1'b1;
      end
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      last      <= GW'(NUM_CH - 1);
      grant     <= '0;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_store <= '0;
      lat_wr    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state == WAIT) ? cnt + CW'(1) : '0;
      if (state == IDLE && any_req) begin
        grant     <= pick;
        lat_addr  <= memaddr[pick*ADDR_W +: ADDR_W];
        lat_store <= memstore[pick*DATA_W +: DATA_W];
        lat_wr    <= memWEN[pick];
      end
      if (state != IDLE && state_n == IDLE) last <= grant;
    end
  end
  always_comb begin
    state_n = (state == IDLE) ? (any_req ? WAIT : IDLE) :
              (state == TOUT || done) ? IDLE :
              (cnt + CW'(1) == CW'(TIMEOUT)) ? TOUT : WAIT;
  end
  always_comb begin
    ramREN   = state == WAIT && !lat_wr;
    ramWEN   = state == WAIT && lat_wr;
    ramaddr  = (state == WAIT) ? lat_addr : '0;
    ramstore = (state == WAIT) ? lat_store : '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chstate[2*i +: 2]          = req[i] ? BUSY : FREE;
      chload[i*DATA_W +: DATA_W] = '0;
    end
    if (state == WAIT) chstate[2*grant +: 2] = (ramstate == ACCESS) ? ACCESS : (ramstate == ERROR) ? ERROR : BUSY;
    if (state == TOUT) chstate[2*grant +: 2] = ERROR;
    if (state == WAIT && ramstate == ACCESS) chload[grant*DATA_W +: DATA_W] = ramload;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random stimulus against a transaction-level reference
// model; expected RAM issues and channel completions are checked by a separate monitor.
module tb_ram_arbiter;
  localparam int N = 4, AW = 32, DW = 32, TO = 8;
  logic CLK = 1'b0, nRST = 1'b1;
  logic [N-1:0] memREN = '0, memWEN = '0;
  logic [N*AW-1:0] memaddr = '0;
  logic [N*DW-1:0] memstore = '0;
  logic [2*N-1:0] chstate;
  logic [N*DW-1:0] chload;
  logic ramREN, ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [1:0] ramstate = 2'd1;
  logic [DW-1:0] ramload = '0;
  logic [1:0] grant;
  int cyc = 0, n_chk = 0, n_pass = 0;
  typedef struct {int cyc; int ch; logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;} ram_t;
  typedef struct {int cyc; int ch; logic [1:0] st; logic [DW-1:0] data;} comp_t;
  ram_t ram_q[$];
  comp_t comp_q[$];
  ram_t cur;
  comp_t cp;
  int m_owner = -1, m_start = 0, m_free = 0, m_last = N - 1, mw;
  int nc, cc;
  logic [DW-1:0] others;
  logic prev_act = 1'b0;

  ram_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .memREN(memREN), .memWEN(memWEN), .memaddr(memaddr),
    .memstore(memstore), .chstate(chstate), .chload(chload), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .ramstate(ramstate),
    .ramload(ramload), .grant(grant)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: one transaction at a time; the arbiter may grant from the cycle
  // after a completion, and a wait longer than TO cycles ends in ERROR one cycle later.
  always @(negedge CLK) begin
    if (!nRST) begin
      m_owner = -1; m_last = N - 1; m_free = 0;
      ram_q.delete(); comp_q.delete();
    end else if (m_owner >= 0) begin
      if (ramstate == 2'd2 || ramstate == 2'd3) begin
        comp_q.push_back('{cyc, m_owner, ramstate, (ramstate == 2'd2) ? ramload : 32'h0});
        m_last = m_owner; m_owner = -1; m_free = cyc + 1;
      end else if (cyc - m_start + 1 == TO) begin
        comp_q.push_back('{cyc + 1, m_owner, 2'd3, 32'h0});
        m_last = m_owner; m_owner = -1; m_free = cyc + 2;
      end
    end else if (cyc >= m_free) begin
      for (int k = 1; k <= N; k++) begin
        mw = (m_last + k) % N;
        if (memREN[mw] || memWEN[mw]) begin
          ram_q.push_back('{cyc + 1, mw, memWEN[mw], memaddr[mw*AW +: AW], memstore[mw*DW +: DW]});
          m_owner = mw; m_start = cyc + 1;
          break;
        end
      end
    end
  end

  always @(negedge CLK) begin
    #1;
    while (ram_q.size() > 0 && ram_q[0].cyc < cyc) begin
      chk("ram_issue_missing", cyc, ram_q[0].cyc);
      void'(ram_q.pop_front());
    end
    while (comp_q.size() > 0 && comp_q[0].cyc < cyc) begin
      chk("completion_missing", cyc, comp_q[0].cyc);
      void'(comp_q.pop_front());
    end
    if ((ramREN || ramWEN) && !prev_act) begin
      chk("ram_issue_expected", ram_q.size() > 0, 1);
      if (ram_q.size() > 0) begin
        cur = ram_q.pop_front();
        chk("ram_issue_cycle", cyc, cur.cyc);
        chk("grant", grant, cur.ch);
        chk("ramWEN", ramWEN, cur.wr);
        chk("ramREN", ramREN, !cur.wr);
      end
    end
    if (ramREN || ramWEN) chk("ram_bus_hold", {ramaddr, ramstore}, {cur.addr, cur.data});
    else chk("ram_bus_idle", {ramaddr, ramstore}, 64'h0);
    prev_act = ramREN || ramWEN;
    nc = 0; cc = -1; others = '0;
    for (int i = 0; i < N; i++) begin
      if (chstate[2*i +: 2] >= 2'd2) begin nc++; cc = i; end
      else others |= chload[i*DW +: DW];
    end
    chk("single_completion", nc <= 1, 1);
    chk("chload_zero", others, 0);
    if (nc == 1) begin
      chk("completion_expected", comp_q.size() > 0, 1);
      if (comp_q.size() > 0) begin
        cp = comp_q.pop_front();
        chk("completion_cycle", cyc, cp.cyc);
        chk("completion_ch", cc, cp.ch);
        chk("completion_state", chstate[2*cc +: 2], cp.st);
        chk("completion_load", chload[cc*DW +: DW], cp.data);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
    #2;
  endtask

  task automatic set_ch(input int i, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    memREN[i] = rd;
    memWEN[i] = wr;
    memaddr[i*AW +: AW] = a;
    memstore[i*DW +: DW] = d;
  endtask

  task automatic idle(input int n);
    memREN = '0;
    memWEN = '0;
    ramstate = 2'd2;
    repeat (n) step();
  endtask

  initial begin
    #1 nRST = 1'b0;
    repeat (2) step();
    sample();
    chk("rst_strobes", {ramREN, ramWEN}, 0);
    chk("rst_grant", grant, 0);
    chk("rst_chstate", chstate, 0);
    chk("rst_chload", chload, 0);
    step(); memREN[1] = 1'b1;
    sample();
    chk("rst_busy", chstate, 8'h04);
    step(); memREN = '0; nRST = 1'b1;
    step();
    set_ch(0, 1, 0, 32'h100, 32'h0);
    step(); memREN[0] = 1'b0; memaddr[AW-1:0] = 32'hFFFF_0000;
    sample();
    chk("rd_strobes", {ramREN, ramWEN}, 2'b10);
    chk("rd_addr", ramaddr, 32'h100);
    step();
    step(); ramstate = 2'd2; ramload = 32'hDEADBEEF;
    sample();
    chk("rd_state", chstate[1:0], 2'd2);
    chk("rd_load", chload[DW-1:0], 32'hDEADBEEF);
    chk("rd_grant", grant, 0);
    idle(2);
    set_ch(2, 1, 1, 32'h40, 32'h55);
    step(); memREN[2] = 1'b0; memWEN[2] = 1'b0;
    sample();
    chk("both_strobes", {ramREN, ramWEN}, 2'b01);
    chk("both_store", ramstore, 32'h55);
    idle(2);
    ramstate = 2'd1;
    set_ch(1, 1, 0, 32'h200, 32'h0);
    step();
    step(); nRST = 1'b0; memREN = 4'hF;
    sample();
    chk("rst_abort", {ramREN, ramWEN}, 0);
    step(); nRST = 1'b1; ramstate = 2'd2;
    step();
    sample();
    chk("post_rst_grant", grant, 0);
    repeat (10) step();
    idle(3);
    set_ch(1, 1, 0, 32'h210, 32'h0);
    repeat (8) step();
    idle(2);
    ramstate = 2'd1;
    set_ch(3, 1, 0, 32'h300, 32'h0);
    step(); memREN[3] = 1'b0;
    repeat (12) step();
    idle(2);
    set_ch(2, 1, 0, 32'h20, 32'h0);
    step(); memREN = '0;
    step();
    ramstate = 2'd3;
    set_ch(3, 0, 1, 32'h330, 32'h77);
    set_ch(0, 1, 0, 32'h10, 32'h0);
    step(); memWEN[3] = 1'b0;
    sample();
    chk("wr_error", chstate[7:6], 2'd3);
    step(); ramstate = 2'd2;
    step();
    sample();
    chk("err_next_grant", grant, 0);
    idle(3);
    repeat (3000) begin
      int r;
      nRST = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N; i++) begin
        memREN[i] = ($urandom_range(0, 2) == 0);
        memWEN[i] = ($urandom_range(0, 3) == 0);
        memaddr[i*AW +: AW] = $urandom;
        memstore[i*DW +: DW] = $urandom;
      end
      r = $urandom_range(0, 9);
      ramstate = (r < 3) ? 2'd2 : (r == 3) ? 2'd3 : (r < 8) ? 2'd1 : 2'd0;
      ramload = $urandom;
      step();
    end
    nRST = 1'b1;
    idle(20);
    chk("drain_ram_q", ram_q.size(), 0);
    chk("drain_comp_q", comp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
